// File: rtl/eth_pkg.sv
// Shared Ethernet TX/RX constants: arbiter FSM encoding, frame limits, preamble bytes.
package eth_pkg;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE  = 2'd0;
  localparam tx_state_t ST_GRANT = 2'd1;
  localparam tx_state_t ST_SEND  = 2'd2;
  localparam tx_state_t ST_IFG   = 2'd3;

  localparam int IFG_DEFAULT           = 12;
  localparam int START_TIMEOUT_DEFAULT = 16;
  localparam int MAX_FRAME_DEFAULT     = 1600;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic OWN_ARP = 1'b0;
  localparam logic OWN_UDP = 1'b1;

  // Round-robin pick: on a tie the requester not served last wins.
  function automatic logic rr_pick(input logic arp, input logic udp, input logic last);
    if (arp && udp) return ~last;
    if (arp)        return OWN_ARP;
    return OWN_UDP;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter.sv
// Frame-level GMII TX arbiter between the ARP responder and UDP TX engine,
// with inter-frame gap, start timeout and runaway-frame watchdogs.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES       = IFG_DEFAULT,
  parameter int START_TIMEOUT    = START_TIMEOUT_DEFAULT,
  parameter int MAX_FRAME_CYCLES = MAX_FRAME_DEFAULT
) (
  input  logic       eth_txc,
  input  logic       rst_n,
  input  logic       arp_req,
  output logic       arp_gnt,
  input  logic       arp_tx_en,
  input  logic [7:0] arp_txd,
  input  logic       udp_req,
  output logic       udp_gnt,
  input  logic       udp_tx_en,
  input  logic [7:0] udp_txd,
  output logic       eth_tx_en,
  output logic [7:0] eth_txd,
  output logic       busy,
  output logic       tx_err
);

  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(START_TIMEOUT - 1);
  localparam logic [15:0] LEN_LAST = 16'(MAX_FRAME_CYCLES - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_err_q, tx_err_d;

  // Only the owner's lane is ever looked at; the other requester is ignored.
  logic       sel_tx_en;
  logic [7:0] sel_txd;
  logic       start_to, len_hit, ifg_done;

  assign sel_tx_en = (owner_q == OWN_UDP) ? udp_tx_en : arp_tx_en;
  assign sel_txd   = (owner_q == OWN_UDP) ? udp_txd   : arp_txd;
  assign start_to  = (cnt_q == TO_LAST);
  assign len_hit   = (cnt_q == LEN_LAST);
  assign ifg_done  = (cnt_q == IFG_LAST);

  always_ff @(posedge eth_txc or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      owner_q  <= OWN_ARP;
      last_q   <= OWN_UDP;
      tx_en_q  <= 1'b0;
      txd_q    <= '0;
      tx_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      tx_en_q  <= tx_en_d;
      txd_q    <= txd_d;
      tx_err_q <= tx_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arp_req || udp_req) begin
          state_d = ST_GRANT;
          owner_d = rr_pick(arp_req, udp_req, last_q);
        end
      end
      ST_GRANT: begin
        if (sel_tx_en) begin
          state_d = ST_SEND;
          last_d  = owner_q;
        end else if (start_to) begin
          state_d = ST_IFG;
        end
      end
      ST_SEND: begin
        if (!sel_tx_en || len_hit) state_d = ST_IFG;
      end
      ST_IFG: begin
        if (ifg_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // One shared counter, restarted on every state change and parked in IDLE.
    cnt_d = (state_d != state_q || state_q == ST_IDLE) ? 16'd0 : cnt_q + 16'd1;
  end

  always_comb begin
    tx_en_d  = 1'b0;
    txd_d    = 8'h00;
    tx_err_d = 1'b0;
    unique case (state_q)
      ST_GRANT: begin
        if (sel_tx_en) begin
          tx_en_d = 1'b1;
          txd_d   = sel_txd;
        end else if (start_to) begin
          tx_err_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (sel_tx_en) begin
          if (len_hit) begin
            tx_err_d = 1'b1;
          end else begin
            tx_en_d = 1'b1;
            txd_d   = sel_txd;
          end
        end
      end
      default: ;
    endcase
  end

  assign arp_gnt   = (state_q == ST_GRANT || state_q == ST_SEND) && (owner_q == OWN_ARP);
  assign udp_gnt   = (state_q == ST_GRANT || state_q == ST_SEND) && (owner_q == OWN_UDP);
  assign busy      = (state_q != ST_IDLE);
  assign eth_tx_en = tx_en_q;
  assign eth_txd   = txd_q;
  assign tx_err    = tx_err_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: stimulus pushes expected grants, bytes and
// error pulses with their cycle numbers; a negedge monitor pops and compares.
module tb_eth_tx_arbiter;
  import eth_pkg::*;

  localparam int IFG  = 12;
  localparam int TO   = 16;
  localparam int MAXF = 1600;

  logic       eth_txc, rst_n;
  logic       arp_req, arp_gnt, arp_tx_en;
  logic [7:0] arp_txd;
  logic       udp_req, udp_gnt, udp_tx_en;
  logic [7:0] udp_txd;
  logic       eth_tx_en, busy, tx_err;
  logic [7:0] eth_txd;

  eth_tx_arbiter #(.IFG_CYCLES(IFG), .START_TIMEOUT(TO), .MAX_FRAME_CYCLES(MAXF)) dut (
    .eth_txc(eth_txc), .rst_n(rst_n),
    .arp_req(arp_req), .arp_gnt(arp_gnt), .arp_tx_en(arp_tx_en), .arp_txd(arp_txd),
    .udp_req(udp_req), .udp_gnt(udp_gnt), .udp_tx_en(udp_tx_en), .udp_txd(udp_txd),
    .eth_tx_en(eth_tx_en), .eth_txd(eth_txd), .busy(busy), .tx_err(tx_err)
  );

  initial eth_txc = 1'b0;
  always #4 eth_txc = ~eth_txc;

  typedef struct { bit who; int cyc; } gnt_exp_t;
  typedef struct { logic [7:0] d; int cyc; } byte_exp_t;

  gnt_exp_t  gq[$];
  byte_exp_t bq[$];
  int        eq[$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int tx_cnt = 0;
  bit mon_en = 0;
  logic arp_gnt_p = 0, udp_gnt_p = 0;
  gnt_exp_t  mg;
  byte_exp_t mb;

  always @(posedge eth_txc) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", nm, cyc);
  endtask

  task automatic tick();
    @(posedge eth_txc);
    #1;
  endtask

  function automatic logic [7:0] fbyte(input bit who, input int i);
    if (i < 7)  return PREAMBLE_BYTE;
    if (i == 7) return SFD_BYTE;
    return 8'(i * 5 + (who ? 128 : 3));
  endfunction

  // Monitor: grants, error pulses and forwarded bytes are matched against the queues.
  always @(negedge eth_txc) begin
    if (mon_en) begin
      if (arp_gnt && !arp_gnt_p) begin
        if (gq.size() == 0) fail_now("arp_gnt_rise");
        else begin
          mg = gq.pop_front();
          chk("gnt_who", 32'(OWN_ARP), 32'(mg.who));
          chk("gnt_cycle", cyc, mg.cyc);
        end
      end
      if (udp_gnt && !udp_gnt_p) begin
        if (gq.size() == 0) fail_now("udp_gnt_rise");
        else begin
          mg = gq.pop_front();
          chk("gnt_who", 32'(OWN_UDP), 32'(mg.who));
          chk("gnt_cycle", cyc, mg.cyc);
        end
      end
      if (arp_gnt && udp_gnt) fail_now("both_gnt");
      if (tx_err) begin
        if (eq.size() == 0) fail_now("tx_err");
        else chk("tx_err_cycle", cyc, eq.pop_front());
      end
      if (eth_tx_en) begin
        tx_cnt++;
        if (bq.size() == 0) fail_now("eth_byte");
        else begin
          mb = bq.pop_front();
          chk("eth_txd", eth_txd, mb.d);
          chk("eth_byte_cycle", cyc, mb.cyc);
        end
      end else begin
        chk("eth_txd_idle", eth_txd, 8'h00);
      end
    end
    arp_gnt_p = arp_gnt;
    udp_gnt_p = udp_gnt;
  end

  // Drives n bytes with tx_en high; the first n_fwd are expected on the PHY side.
  task automatic send_frame(input bit who, input int n, input int n_fwd,
                            input int req_at, input logic [1:0] req_val, output int e);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = fbyte(who, i);
      if (i == req_at) {udp_req, arp_req} = req_val;
      if (who) begin udp_tx_en = 1'b1; udp_txd = d; end
      else     begin arp_tx_en = 1'b1; arp_txd = d; end
      if (i < n_fwd) bq.push_back('{d, cyc + 1});
      chk("gnt_in_frame", who ? udp_gnt : arp_gnt, 32'(i <= n_fwd));
      tick();
    end
    arp_tx_en = 1'b0; arp_txd = 8'h00;
    udp_tx_en = 1'b0; udp_txd = 8'h00;
    e = cyc;
  endtask

  task automatic wait_idle(output int c);
    int k = 0;
    while (busy && k < 100) begin tick(); k++; end
    if (busy) fail_now("idle_wait_expired");
    c = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int c, e, e2, s, b, tx0;
    rst_n = 1'b0;
    arp_req = 0; arp_tx_en = 0; arp_txd = 0;
    udp_req = 0; udp_tx_en = 0; udp_txd = 0;
    tick(); tick();
    chk("rst_arp_gnt", arp_gnt, 0);
    chk("rst_udp_gnt", udp_gnt, 0);
    chk("rst_eth_tx_en", eth_tx_en, 0);
    chk("rst_eth_txd", eth_txd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_err", tx_err, 0);
    rst_n = 1'b1;
    tick();
    mon_en = 1;

    // Single 72-byte ARP frame.
    c = cyc;
    arp_req = 1; gq.push_back('{OWN_ARP, c + 1});
    tick();
    chk("t1_gnt", arp_gnt, 1);
    chk("t1_busy", busy, 1);
    arp_req = 0;
    tick();
    send_frame(OWN_ARP, 72, 72, -1, 2'b00, e);
    tick();
    chk("t1_gnt_drop", arp_gnt, 0);
    chk("t1_tx_en_drop", eth_tx_en, 0);
    wait_idle(b);
    chk("t1_busy_fall", b, c + 87);

    // Tie straight after reset: ARP first, UDP at e+IFG+2.
    do_reset();
    c = cyc;
    arp_req = 1; udp_req = 1; gq.push_back('{OWN_ARP, c + 1});
    tick();
    arp_req = 0;
    tick();
    send_frame(OWN_ARP, 10, 10, -1, 2'b00, e);
    gq.push_back('{OWN_UDP, e + IFG + 2});
    while (cyc < e + IFG + 1) tick();
    chk("t2_udp_wait", udp_gnt, 0);
    chk("t2_idle", busy, 0);
    tick();
    chk("t2_udp_gnt", udp_gnt, 1);
    udp_req = 0;
    tick();
    send_frame(OWN_UDP, 8, 8, -1, 2'b00, e);
    wait_idle(b);

    // Requests raised mid-frame wait for IFG; the tie then goes to UDP.
    c = cyc;
    arp_req = 1; gq.push_back('{OWN_ARP, c + 1});
    tick();
    arp_req = 0;
    tick();
    send_frame(OWN_ARP, 20, 20, 10, 2'b11, e);
    gq.push_back('{OWN_UDP, e + IFG + 2});
    while (cyc < e + IFG + 2) begin
      tick();
      if (cyc < e + IFG + 2) chk("t3_udp_held", udp_gnt, 0);
    end
    chk("t3_rr_udp", udp_gnt, 1);
    chk("t3_arp_waits", arp_gnt, 0);
    udp_req = 0;
    tick();
    send_frame(OWN_UDP, 16, 16, -1, 2'b00, e2);
    gq.push_back('{OWN_ARP, e2 + IFG + 2});
    while (cyc < e2 + IFG + 2) tick();
    chk("t3_arp_next", arp_gnt, 1);
    arp_req = 0;
    tick();
    send_frame(OWN_ARP, 12, 12, -1, 2'b00, e);
    wait_idle(b);

    // Start timeout: UDP granted but silent; ARP's stray tx_en must be ignored.
    c = cyc;
    udp_req = 1; gq.push_back('{OWN_UDP, c + 1}); eq.push_back(c + TO + 1);
    tick();
    udp_req = 0; arp_tx_en = 1; arp_txd = 8'hAA;
    for (int k = 1; k <= 20; k++) begin
      chk("t4_eth_tx_en", eth_tx_en, 0);
      chk("t4_udp_gnt", udp_gnt, 32'(k <= TO));
      tick();
    end
    arp_tx_en = 0; arp_txd = 0;
    wait_idle(b);
    chk("t4_idle", b, c + TO + IFG + 1);

    // Runaway ARP frame: 2000 bytes offered, 1600 forwarded, one tx_err.
    tx0 = tx_cnt;
    c = cyc;
    arp_req = 1; gq.push_back('{OWN_ARP, c + 1});
    tick();
    arp_req = 0;
    tick();
    s = cyc;
    eq.push_back(s + MAXF + 1);
    send_frame(OWN_ARP, 2000, MAXF, -1, 2'b00, e);
    tick();
    chk("t5_tx_en_cycles", tx_cnt - tx0, MAXF);
    chk("t5_idle", busy, 0);

    // Reset pulled at byte 30 of a UDP frame.
    c = cyc;
    udp_req = 1; gq.push_back('{OWN_UDP, c + 1});
    tick();
    udp_req = 0;
    tick();
    send_frame(OWN_UDP, 30, 30, -1, 2'b00, e);
    @(negedge eth_txc);
    #1;
    chk("t6_live_before_rst", eth_tx_en, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_udp_gnt", udp_gnt, 0);
    chk("t6_arp_gnt", arp_gnt, 0);
    chk("t6_eth_tx_en", eth_tx_en, 0);
    chk("t6_eth_txd", eth_txd, 0);
    chk("t6_busy", busy, 0);
    chk("t6_tx_err", tx_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    c = cyc;
    udp_req = 1; gq.push_back('{OWN_UDP, c + 1});
    tick();
    chk("t6_regrant", udp_gnt, 1);
    udp_req = 0;
    tick();
    send_frame(OWN_UDP, 9, 9, -1, 2'b00, e);
    wait_idle(b);
    chk("t6_idle", b, e + IFG + 1);

    tick();
    chk("gnt_q_drained", gq.size(), 0);
    chk("byte_q_drained", bq.size(), 0);
    chk("err_q_drained", eq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
